// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registered ALU command front-end
// with a credit-gated in-order response FIFO.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_y,
  input  logic             alu_carry,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      y;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  logic             s1_valid;
  logic             s1_err;
  logic [TAG_W-1:0] s1_tag;

  rsp_t             mem [DEPTH];
  rsp_t             wr_ent;
  rsp_t             hd_ent;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [AW+1:0]    used;

  logic accept;
  logic push;
  logic pop;

  // Credit counts the S1 entry too, so a push never finds the FIFO full.
  assign used      = {1'b0, count} + (AW+2)'(s1_valid);
  assign cmd_ready = !rst && (used < (AW+2)'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = s1_valid;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wr_ent       = '0;
    wr_ent.tag   = s1_tag;
    wr_ent.err   = s1_err;
    if (!s1_err) begin
      wr_ent.y     = alu_y;
      wr_ent.flags = {alu_ovf, alu_carry,
                      alu_neg, alu_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_err      <= 1'b0;
      s1_tag      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        alu_a       <= cmd_a;
        alu_b       <= cmd_b;
        alu_control <= cmd_op;
        s1_tag      <= cmd_tag;
        s1_err      <= (cmd_op >= 4'd13);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ops_done <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_ent;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr     <= rptr + 1'b1;
        ops_done <= ops_done + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign hd_ent    = mem[rptr];
  assign rsp_y     = hd_ent.y;
  assign rsp_flags = hd_ent.flags;
  assign rsp_tag   = hd_ent.tag;
  assign rsp_err   = hd_ent.err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: ALU stub, queue-based response
// model checked every cycle, plus directed literal checks.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [31:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      alu_a, alu_b;
  logic [3:0]       alu_control;
  logic [31:0]      alu_y;
  logic             alu_carry, alu_neg, alu_zero, alu_ovf;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_y;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [15:0]      ops_done;

  int cmp_n = 0;
  int bad_n = 0;
  logic live = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control),
    .alu_y(alu_y), .alu_carry(alu_carry),
    .alu_neg(alu_neg), .alu_zero(alu_zero),
    .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  // Returns {y, ovf, carry, neg, zero}; illegal ops give junk
  // so that the forced-zero response path is observable.
  function automatic logic [35:0] alu_ref(
    input logic [3:0] op, input logic [31:0] a, b);
    logic [32:0] s;
    logic [31:0] y;
    logic c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = a ^ b;
      4'd3: y = ~(a & b);
      4'd4: y = ~(a | b);
      4'd5: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      4'd6: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      4'd7: y = {31'd0, $signed(a) < $signed(b)};
      4'd8: y = a << b[4:0];
      4'd9: y = a >> b[4:0];
      4'd10: y = $signed(a) >>> b[4:0];
      4'd11: y = a;
      4'd12: y = b;
      default: return {32'hBAD0BAD0, 4'hF};
    endcase
    return {y, v, c, y[31], y == 32'd0};
  endfunction

  always_comb
    {alu_y, alu_ovf, alu_carry, alu_neg, alu_zero} =
      alu_ref(alu_control, alu_a, alu_b);

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h, want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: every accepted-but-not-popped request is one queue entry;
  // an entry becomes visible one edge after its accept edge.
  typedef struct {
    logic [31:0]      y;
    logic [3:0]       f;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               vis;
  } exp_t;

  exp_t        q[$];
  int          ecnt = 0;
  int unsigned done_m = 0;
  logic [31:0] ea = '0, eb = '0;
  logic [3:0]  ec = '0;

  function automatic logic m_ready();
    return !rst && (q.size() < DEPTH);
  endfunction

  function automatic logic m_valid();
    return (q.size() > 0) && (q[0].vis <= ecnt);
  endfunction

  always @(posedge clk) begin
    logic er, ev;
    logic [35:0] r;
    exp_t e;
    er = m_ready();
    ev = m_valid();
    ecnt++;
    if (rst) begin
      q.delete();
      done_m = 0;
      ea = '0; eb = '0; ec = '0;
    end else begin
      if (ev && rsp_ready) begin
        void'(q.pop_front());
        done_m++;
      end
      if (cmd_valid && er) begin
        r     = alu_ref(cmd_op, cmd_a, cmd_b);
        e.err = (cmd_op >= 4'd13);
        e.y   = e.err ? 32'd0 : r[35:4];
        e.f   = e.err ? 4'd0 : r[3:0];
        e.tag = cmd_tag;
        e.vis = ecnt + 1;
        q.push_back(e);
        ea = cmd_a; eb = cmd_b; ec = cmd_op;
      end
    end
    if (live && q.size() > DEPTH)
      chk("no_overflow", 64'(q.size()), 64'(DEPTH));
  end

  always @(negedge clk) begin
    if (live) begin
      chk("m_cmd_ready", cmd_ready, m_ready());
      chk("m_rsp_valid", rsp_valid, m_valid());
      chk("m_ops_done", ops_done, 64'(done_m[15:0]));
      chk("m_alu_a", alu_a, ea);
      chk("m_alu_b", alu_b, eb);
      chk("m_alu_ctl", alu_control, ec);
      if (m_valid()) begin
        chk("m_rsp_y", rsp_y, q[0].y);
        chk("m_rsp_flags", rsp_flags, q[0].f);
        chk("m_rsp_tag", rsp_tag, q[0].tag);
        chk("m_rsp_err", rsp_err, q[0].err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op,
                      input logic [31:0] a, b,
                      input logic [3:0] tag);
    int k;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    k = 0;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    chk("send_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < 50) begin
      step();
      k++;
    end
    chk("rsp_timeout", rsp_valid, 1'b1);
  endtask

  task automatic pop1();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    rsp_ready = 1'b1;
    while ((rsp_valid || k < 2) && k < 50) begin
      step();
      k++;
    end
    chk("drain_empty", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, k;
    logic acc;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    step(); step();
    live = 1'b1;
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_ctl", alu_control, 4'd0);
    chk("rst_done", ops_done, 16'd0);
    chk("rst_y", rsp_y, 32'd0);
    chk("rst_tag", rsp_tag, 4'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1'b1);

    send(4'd6, 32'd5, 32'd7, 4'd3);
    chk("lat_e1", rsp_valid, 1'b0);
    step();
    chk("lat_e2", rsp_valid, 1'b1);
    chk("add_y", rsp_y, 32'd12);
    chk("add_z", rsp_flags[0], 1'b0);
    chk("add_c", rsp_flags[2], 1'b0);
    chk("add_tag", rsp_tag, 4'd3);
    chk("add_err", rsp_err, 1'b0);
    pop1();
    chk("done_1", ops_done, 16'd1);

    send(4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 4'd1);
    wait_rsp();
    chk("sub_y", rsp_y, 32'd0);
    chk("sub_z", rsp_flags[0], 1'b1);
    pop1();
    send(4'd4, 32'd0, 32'd0, 4'd2);
    wait_rsp();
    chk("nor_y", rsp_y, 32'hFFFFFFFF);
    chk("nor_z", rsp_flags[0], 1'b0);
    pop1();

    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 4'd6; cmd_b = 32'd100;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cmd_tag = 4'(n); cmd_a = 32'(n);
      acc = cmd_ready;
      step();
      if (acc) n++;
    end
    cmd_valid = 1'b0;
    chk("bp_accepts", 64'(n), 64'd4);
    chk("bp_ready0", cmd_ready, 1'b0);
    chk("bp_head0", rsp_tag, 4'd0);
    pop1();
    chk("bp_ready1", cmd_ready, 1'b1);
    chk("bp_head1", rsp_tag, 4'd1);
    drain();
    chk("done_7", ops_done, 16'd7);

    send(4'd14, 32'd1, 32'd1, 4'd9);
    wait_rsp();
    chk("ill_err", rsp_err, 1'b1);
    chk("ill_y", rsp_y, 32'd0);
    chk("ill_flags", rsp_flags, 4'd0);
    chk("ill_tag", rsp_tag, 4'd9);
    pop1();
    chk("done_8", ops_done, 16'd8);

    for (int i = 0; i < 4; i++)
      send(4'd6, 32'(i), 32'd1, 4'(10 + i));
    pop1();
    chk("full_head", rsp_tag, 4'd11);
    chk("full_y", rsp_y, 32'd2);
    chk("done_9", ops_done, 16'd9);
    drain();

    n = 0; k = 0;
    cmd_valid = 1'b1;
    while (n < 32 && k < 1000) begin
      cmd_op  = 4'($urandom_range(0, 15));
      cmd_a   = $urandom;
      cmd_b   = $urandom;
      cmd_tag = 4'(n);
      rsp_ready = 1'($urandom_range(0, 1));
      acc = cmd_ready;
      step();
      if (acc) n++;
      k++;
    end
    cmd_valid = 1'b0;
    chk("rand_accepts", 64'(n), 64'd32);
    drain();

    for (int i = 1; i <= 3; i++)
      send(4'd11, 32'(i), 32'd0, 4'(i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 1'b0);
    chk("mid_done", ops_done, 16'd0);
    chk("mid_ctl", alu_control, 4'd0);
    chk("mid_ready", cmd_ready, 1'b1);
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("mid_no_stale", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
    send(4'd12, 32'd0, 32'h1234, 4'd5);
    wait_rsp();
    chk("mid_tag", rsp_tag, 4'd5);
    chk("mid_y", rsp_y, 32'h1234);
    pop1();
    chk("mid_done1", ops_done, 16'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, bad_n);
    $finish;
  end

endmodule
